// File: rtl/exu_branch_unit.sv
// exu_branch_unit: multi-cycle branch/JAL/JALR execution unit with its own regfile read sequencing and link writeback.
// Define EXU_BRANCH_MISALIGN_EXC_EN to add exc_misalign, which suppresses redirects to misaligned targets.
module exu_branch_unit #(
  parameter int XLEN = 32,
  parameter int PC_OFFSET = 8,
  parameter int RD_LAT = 1,
  parameter int HOLD_CYCLES = 2,
  localparam int D = PC_OFFSET / 4,
  localparam int FW = $clog2(D + 1)
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic            start,
  input  logic [2:0]      dec_funct3,
  input  logic            dec_branch,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic [12:0]     dec_imm_b,
  input  logic [20:0]     dec_imm_j,
  input  logic [11:0]     dec_imm_i,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      reg_raddr_1,
  output logic [4:0]      reg_raddr_2,
  output logic            reg_ren_1,
  output logic            reg_ren_2,
  input  logic [XLEN-1:0] reg_rdata_1,
  input  logic [XLEN-1:0] reg_rdata_2,
  output logic [4:0]      reg_waddr,
  output logic            reg_wen,
  output logic [XLEN-1:0] reg_wdata,
  output logic            pc_write,
  output logic [XLEN-1:0] pc_wdata,
  output logic [FW-1:0]   flush,
  output logic            busy,
  output logic            done
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
  ,
  output logic            exc_misalign
`endif
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, RESP} state_t;
  localparam int CMAX = RD_LAT > HOLD_CYCLES ? RD_LAT : HOLD_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pc_s_q, pc_s_d, op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0] pc_wdata_q, pc_wdata_d, reg_wdata_q, reg_wdata_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [4:0] reg_waddr_q, reg_waddr_d;
  logic pc_write_q, pc_write_d, reg_wen_q, reg_wen_d, exc_q, exc_d;
  logic [XLEN-1:0] target, delta;
  logic eq, lt, ltu, cmp, taken, near, mis, link, redirect;
  always_comb begin
    eq = op1_q == op2_q;
    lt = $signed(op1_q) < $signed(op2_q);
    ltu = op1_q < op2_q;
    cmp = dec_funct3[2:1] == 2'b00 ? eq : dec_funct3[1] ? ltu : lt;
    taken = dec_jal | dec_jalr | (dec_branch & dec_funct3[2:1] != 2'b01 & (cmp ^ dec_funct3[0]));
    target = dec_jal ? pc_s_q + {{(XLEN-21){dec_imm_j[20]}}, dec_imm_j}
           : dec_jalr ? (op1_q + {{(XLEN-12){dec_imm_i[11]}}, dec_imm_i}) & ~XLEN'(1)
           : pc_s_q + {{(XLEN-13){dec_imm_b[12]}}, dec_imm_b};
    delta = target - pc_s_q;
    // short forward hops land inside the already-fetched window: just kill the skipped slots
    near = delta[1:0] == 2'b00 && delta >= XLEN'(4) && delta <= XLEN'(4 * D);
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
    mis = taken && target[1:0] != 2'b00;
`else
    mis = 1'b0;
`endif
    redirect = taken && !near && !mis;
    link = (dec_jal | dec_jalr) && dec_rd != 5'd0 && !mis;
    state_d = state_q;
    cnt_d = cnt_q;
    pc_s_d = pc_s_q;
    op1_d = op1_q;
    op2_d = op2_q;
    pc_write_d = pc_write_q;
    pc_wdata_d = pc_wdata_q;
    flush_d = flush_q;
    exc_d = exc_q;
    reg_wen_d = 1'b0;
    reg_waddr_d = '0;
    reg_wdata_d = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        pc_s_d = pc - XLEN'(PC_OFFSET);
      end
      READ: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: if (cnt_q == CW'(RD_LAT - 1)) begin
        state_d = EVAL;
        cnt_d = '0;
        op1_d = reg_rdata_1;
        op2_d = reg_rdata_2;
      end else cnt_d = cnt_q + 1'b1;
      EVAL: begin
        state_d = RESP;
        pc_write_d = redirect;
        pc_wdata_d = redirect ? target : '0;
        flush_d = !taken ? '0 : near ? FW'(delta[XLEN-1:2] - 1'b1) : FW'(D);
        exc_d = mis;
        reg_wen_d = link;
        reg_waddr_d = link ? dec_rd : '0;
        reg_wdata_d = link ? pc_s_q + XLEN'(4) : '0;
      end
      RESP: if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        state_d = IDLE;
        cnt_d = '0;
        pc_write_d = 1'b0;
        pc_wdata_d = '0;
        flush_d = '0;
        exc_d = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pc_s_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      pc_write_q <= 1'b0;
      pc_wdata_q <= '0;
      flush_q <= '0;
      exc_q <= 1'b0;
      reg_wen_q <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_s_q <= pc_s_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      pc_write_q <= pc_write_d;
      pc_wdata_q <= pc_wdata_d;
      flush_q <= flush_d;
      exc_q <= exc_d;
      reg_wen_q <= reg_wen_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == RESP && cnt_q == CW'(HOLD_CYCLES - 1);
  assign reg_ren_1 = state_q == READ && !dec_jal;
  assign reg_ren_2 = state_q == READ && dec_branch;
  assign reg_raddr_1 = reg_ren_1 ? dec_rs1 : '0;
  assign reg_raddr_2 = reg_ren_2 ? dec_rs2 : '0;
  assign reg_wen = reg_wen_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign pc_write = pc_write_q;
  assign pc_wdata = pc_wdata_q;
  assign flush = flush_q;
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
  assign exc_misalign = exc_q;
`endif
endmodule

// File: tb/tb_exu_branch_unit.sv
// tb_exu_branch_unit: vector table, random and reset/busy sequences against two configurations of exu_branch_unit.
module tb_exu_branch_unit;
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
  localparam bit MX = 1'b1;
`else
  localparam bit MX = 1'b0;
`endif
  typedef struct {
    bit sel; int ty; logic [2:0] f3; logic [4:0] rs1, rs2, rd;
    logic [31:0] a, b, pc; logic [20:0] imm;
    logic pw; logic [31:0] wd; logic [1:0] fl; logic wen; logic [31:0] lw; logic exc;
  } vec_t;

  logic hclk = 0, hrst = 1, start = 0;
  logic [2:0] dec_funct3 = 0;
  logic dec_branch = 0, dec_jal = 0, dec_jalr = 0;
  logic [12:0] dec_imm_b = 0;
  logic [20:0] dec_imm_j = 0;
  logic [11:0] dec_imm_i = 0;
  logic [4:0] dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0;
  logic [31:0] pc = 0;
  bit sel = 0;
  logic start_0, start_1;
  logic [4:0] ra1_0, ra2_0, wa_0, ra1_1, ra2_1, wa_1;
  logic ren1_0, ren2_0, wen_0, pw_0, busy_0, done_0, exc_0;
  logic ren1_1, ren2_1, wen_1, pw_1, busy_1, done_1, exc_1;
  logic [31:0] rd1_0 = 0, rd2_0 = 0, rd1_1 = 0, rd2_1 = 0, wdat_0, wd_0, wdat_1, wd_1;
  logic [1:0] fl_0, fl_1;
  logic [31:0] regs [32];
  int total = 0, bad = 0, vid = 0;

  always #5 hclk = ~hclk;
  assign start_0 = start & !sel;
  assign start_1 = start & sel;

  exu_branch_unit u0 (
    .hclk(hclk), .hrst(hrst), .start(start_0), .dec_funct3(dec_funct3), .dec_branch(dec_branch),
    .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_imm_b(dec_imm_b), .dec_imm_j(dec_imm_j),
    .dec_imm_i(dec_imm_i), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .pc(pc),
    .reg_raddr_1(ra1_0), .reg_raddr_2(ra2_0), .reg_ren_1(ren1_0), .reg_ren_2(ren2_0),
    .reg_rdata_1(rd1_0), .reg_rdata_2(rd2_0), .reg_waddr(wa_0), .reg_wen(wen_0), .reg_wdata(wdat_0),
    .pc_write(pw_0), .pc_wdata(wd_0), .flush(fl_0), .busy(busy_0), .done(done_0)
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
    , .exc_misalign(exc_0)
`endif
  );

  exu_branch_unit #(.PC_OFFSET(12), .RD_LAT(3)) u1 (
    .hclk(hclk), .hrst(hrst), .start(start_1), .dec_funct3(dec_funct3), .dec_branch(dec_branch),
    .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_imm_b(dec_imm_b), .dec_imm_j(dec_imm_j),
    .dec_imm_i(dec_imm_i), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .pc(pc),
    .reg_raddr_1(ra1_1), .reg_raddr_2(ra2_1), .reg_ren_1(ren1_1), .reg_ren_2(ren2_1),
    .reg_rdata_1(rd1_1), .reg_rdata_2(rd2_1), .reg_waddr(wa_1), .reg_wen(wen_1), .reg_wdata(wdat_1),
    .pc_write(pw_1), .pc_wdata(wd_1), .flush(fl_1), .busy(busy_1), .done(done_1)
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
    , .exc_misalign(exc_1)
`endif
  );
`ifndef EXU_BRANCH_MISALIGN_EXC_EN
  assign exc_0 = 1'b0;
  assign exc_1 = 1'b0;
`endif

  // regfile returns data only for addresses actually enabled
  always @(posedge hclk) begin
    if (ren1_0) rd1_0 <= regs[ra1_0];
    if (ren2_0) rd2_0 <= regs[ra2_0];
    if (ren1_1) rd1_1 <= regs[ra1_1];
    if (ren2_1) rd2_1 <= regs[ra2_1];
  end

  logic c_pw, c_wen, c_ren1, c_ren2, c_busy, c_done, c_exc, c_nz;
  logic [31:0] c_wd, c_wdat;
  logic [1:0] c_fl;
  logic [4:0] c_wa, c_ra1, c_ra2;
  always_comb begin
    c_pw = sel ? pw_1 : pw_0;
    c_wd = sel ? wd_1 : wd_0;
    c_fl = sel ? fl_1 : fl_0;
    c_wen = sel ? wen_1 : wen_0;
    c_wa = sel ? wa_1 : wa_0;
    c_wdat = sel ? wdat_1 : wdat_0;
    c_ren1 = sel ? ren1_1 : ren1_0;
    c_ren2 = sel ? ren2_1 : ren2_0;
    c_ra1 = sel ? ra1_1 : ra1_0;
    c_ra2 = sel ? ra2_1 : ra2_0;
    c_busy = sel ? busy_1 : busy_0;
    c_done = sel ? done_1 : done_0;
    c_exc = sel ? exc_1 : exc_0;
    c_nz = c_pw | (|c_wd) | (|c_fl) | c_wen | (|c_wa) | (|c_wdat) | c_ren1 | c_ren2 |
           (|c_ra1) | (|c_ra2) | c_busy | c_done | c_exc;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %h want %h", vid, n, act, exp);
    end
  endtask

  function automatic vec_t mk(bit s, int ty, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                              logic [31:0] p, logic [20:0] imm, logic [4:0] rd, logic pw,
                              logic [31:0] wd, logic [1:0] fl, logic wen, logic [31:0] lw, logic exc);
    vec_t v;
    v.sel = s; v.ty = ty; v.f3 = f3; v.a = a; v.b = b; v.pc = p; v.imm = imm; v.rd = rd;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.pw = pw; v.wd = wd; v.fl = fl; v.wen = wen; v.lw = lw; v.exc = exc;
    return v;
  endfunction

  // reference: branch rules evaluated with plain integer arithmetic
  function automatic vec_t model(input vec_t v);
    int d, off, ib, ij, ii;
    logic [31:0] ps, tgt, dl;
    bit tk, near, mis;
    d = v.sel ? 3 : 2;
    off = v.sel ? 12 : 8;
    ib = $signed(v.imm[12:0]);
    ij = $signed(v.imm);
    ii = $signed(v.imm[11:0]);
    ps = v.pc - 32'(off);
    tk = 0;
    tgt = ps;
    if (v.ty == 0) begin
      tgt = ps + 32'(ib);
      case (v.f3)
        3'd0: tk = v.a == v.b;
        3'd1: tk = v.a != v.b;
        3'd4: tk = $signed(v.a) < $signed(v.b);
        3'd5: tk = $signed(v.a) >= $signed(v.b);
        3'd6: tk = v.a < v.b;
        3'd7: tk = v.a >= v.b;
        default: tk = 0;
      endcase
    end else if (v.ty == 1) begin
      tk = 1;
      tgt = ps + 32'(ij);
    end else if (v.ty == 2) begin
      tk = 1;
      tgt = (v.a + 32'(ii)) & 32'hFFFF_FFFE;
    end
    dl = tgt - ps;
    near = tk && dl % 4 == 0 && dl / 4 >= 1 && dl / 4 <= 32'(d);
    mis = MX && tk && tgt % 4 != 0;
    v.pw = tk && !near && !mis;
    v.wd = v.pw ? tgt : 32'd0;
    v.fl = !tk ? 2'd0 : near ? 2'(dl / 4 - 1) : 2'(d);
    v.wen = (v.ty == 1 || v.ty == 2) && v.rd != 0 && !mis;
    v.lw = ps + 4;
    v.exc = mis;
    return v;
  endfunction

  task automatic setdec(input vec_t v);
    sel = v.sel;
    regs[v.rs1] = v.a;
    regs[v.rs2] = v.b;
    dec_funct3 = v.f3;
    dec_branch = v.ty == 0;
    dec_jal = v.ty == 1;
    dec_jalr = v.ty == 2;
    dec_imm_b = v.imm[12:0];
    dec_imm_j = v.imm;
    dec_imm_i = v.imm[11:0];
    dec_rs1 = v.rs1;
    dec_rs2 = v.rs2;
    dec_rd = v.rd;
    pc = v.pc;
  endtask

  task automatic txn(input vec_t v, input bit extra);
    int e0, de, pwc, flc, wenc, excc, r1c, r2c, wen_e;
    logic held, badaddr, notbusy, nz, cpw, cexc;
    logic [31:0] cwd, cwdat;
    logic [1:0] cfl;
    logic [4:0] cwa;
    e0 = v.sel ? 6 : 4;
    de = 0; pwc = 0; flc = 0; wenc = 0; excc = 0; r1c = 0; r2c = 0; wen_e = 0;
    held = 1; badaddr = 0; notbusy = 0; nz = 0; cpw = 0; cexc = 0; cwd = 0; cwdat = 0; cfl = 0; cwa = 0;
    setdec(v);
    start = 1'b1;
    @(posedge hclk);
    #1 start = 1'b0;
    for (int e = 1; e < 30 && de == 0; e++) begin
      @(negedge hclk);
      if (c_ren1) begin r1c++; if (c_ra1 != v.rs1) badaddr = 1; end
      if (c_ren2) begin r2c++; if (c_ra2 != v.rs2) badaddr = 1; end
      if (!c_busy) notbusy = 1;
      if (c_pw) pwc++;
      if (c_fl != 0) flc++;
      if (c_exc) excc++;
      if (e == e0) begin cpw = c_pw; cwd = c_wd; cfl = c_fl; cexc = c_exc; end
      if (e > e0 && {c_pw, c_wd, c_fl} != {cpw, cwd, cfl}) held = 0;
      if (c_wen) begin wenc++; cwa = c_wa; cwdat = c_wdat; wen_e = e; end
      if (c_done) de = e;
      @(posedge hclk);
      #1;
      if (extra) start = e + 1 == 2;
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      nz |= c_nz;
      @(posedge hclk);
      #1;
    end
    chk("done_edge", de, e0 + 1);
    chk("pc_write", cpw, v.pw);
    chk("pc_wdata", cwd, v.wd);
    chk("flush", cfl, v.fl);
    chk("resp_held", held, 1);
    chk("pw_cycles", pwc, v.pw ? 2 : 0);
    chk("flush_cycles", flc, v.fl != 0 ? 2 : 0);
    chk("wen_cycles", wenc, v.wen);
    if (v.wen) begin
      chk("wen_edge", wen_e, e0);
      chk("waddr", cwa, v.rd);
      chk("wdata", cwdat, v.lw);
    end
    chk("ren1_cycles", r1c, v.ty == 1 ? 0 : 1);
    chk("ren2_cycles", r2c, v.ty == 0 ? 1 : 0);
    chk("raddr", badaddr, 0);
    chk("busy_gap", notbusy, 0);
    chk("idle_after", nz, 0);
`ifdef EXU_BRANCH_MISALIGN_EXC_EN
    chk("exc", cexc, v.exc);
    chk("exc_cycles", excc, v.exc ? 2 : 0);
`endif
  endtask

  vec_t tv[$];
  initial begin
    vec_t v;
    logic pws, dns;
    for (int i = 0; i < 32; i++) regs[i] = 0;
    tv.push_back(mk(0, 0, 3'd0, 5, 5, 32'h108, 21'h40, 0, 1, 32'h140, 2, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd1, 5, 5, 32'h108, 21'h40, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd4, 32'hFFFF_FFFF, 1, 32'h108, 21'h8, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd6, 32'hFFFF_FFFF, 1, 32'h108, 21'h8, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 2, 3'd0, 32'h203, 0, 32'h58, 21'h0, 1, !MX, MX ? 32'h0 : 32'h202, 2, !MX, 32'h54, MX));
    tv.push_back(mk(0, 2, 3'd0, 32'h203, 0, 32'h58, 21'h0, 0, !MX, MX ? 32'h0 : 32'h202, 2, 0, 32'h54, MX));
    tv.push_back(mk(0, 1, 3'd0, 0, 0, 32'h108, 21'h4, 5, 0, 0, 0, 1, 32'h104, 0));
    tv.push_back(mk(0, 1, 3'd0, 0, 0, 32'h108, 21'h1FFFFC, 0, 1, 32'hFC, 2, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd0, 7, 7, 32'h108, 21'h0, 0, 1, 32'h100, 2, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd2, 5, 5, 32'h108, 21'h8, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 3, 3'd0, 5, 5, 32'h108, 21'h8, 3, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd7, 32'hFFFF_FFFF, 1, 32'h108, 21'h8, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(mk(0, 0, 3'd5, 32'hFFFF_FFFF, 1, 32'h108, 21'h8, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 3'd0, 0, 0, 32'h4, 21'h8, 2, 0, 0, 1, 1, 32'h0, 0));
    tv.push_back(mk(0, 1, 3'd0, 0, 0, 32'h108, 21'hC, 0, 1, 32'h10C, 2, 0, 0, 0));
    tv.push_back(mk(0, 2, 3'd0, 32'h105, 0, 32'h108, 21'h0, 3, 0, 0, 0, 1, 32'h104, 0));
    tv.push_back(mk(1, 1, 3'd0, 0, 0, 32'h10C, 21'hC, 0, 0, 0, 2, 0, 0, 0));
    tv.push_back(mk(1, 1, 3'd0, 0, 0, 32'h10C, 21'h6, 4, !MX, MX ? 32'h0 : 32'h106, 3, !MX, 32'h104, MX));
    repeat (3) @(posedge hclk);
    #1 hrst = 0;
    @(negedge hclk);
    sel = 0; #1 chk("reset_u0", c_nz, 0);
    sel = 1; #1 chk("reset_u1", c_nz, 0);
    @(posedge hclk);
    #1;
    for (int i = 0; i < tv.size(); i++) begin
      vid = i;
      txn(tv[i], 1'b0);
    end
    vid = 100;
    txn(tv[0], 1'b1);
    vid = 200;
    setdec(tv[0]);
    start = 1'b1;
    @(posedge hclk);
    #1 start = 1'b0;
    @(posedge hclk);
    #1 hrst = 1'b1;
    @(posedge hclk);
    #1 hrst = 1'b0;
    @(negedge hclk);
    chk("rst_wait_idle", c_nz, 0);
    pws = 0; dns = 0;
    repeat (8) begin
      @(negedge hclk);
      pws |= c_pw;
      dns |= c_done;
    end
    chk("rst_no_pw", pws, 0);
    chk("rst_no_done", dns, 0);
    @(posedge hclk);
    #1;
    for (int i = 0; i < 80; i++) begin
      int off;
      vid = 300 + i;
      v.sel = $urandom_range(0, 3) == 0;
      off = v.sel ? 12 : 8;
      v.ty = $urandom_range(0, 5);
      if (v.ty > 3) v.ty = 0;
      v.f3 = 3'($urandom);
      v.rs1 = 5'($urandom_range(1, 15));
      v.rs2 = 5'($urandom_range(16, 31));
      v.rd = 5'($urandom_range(0, 3));
      v.pc = $urandom & 32'hFFFF_FFFC;
      v.b = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : 32'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: v.a = v.b;
        1: v.a = v.b + 1;
        2: v.a = v.pc - 32'(off) + 32'($urandom_range(0, 16));
        default: v.a = $urandom;
      endcase
      v.imm = $urandom_range(0, 1) ? 21'($urandom) : 21'(int'($urandom_range(0, 40)) - 20);
      txn(model(v), 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
